uart_ram_wr_ctrl: RTL and testbench
===================================

Name: uart_ram_wr_ctrl

Overview:
- Write-side controller for the 16-bit x 64K dual-port frame RAM between the UART receiver and the TFT display.
- Takes bytes from the UART byte receiver and packs each byte pair into one RGB565 pixel.
- Drives RAM port A (ena/wea/addra/dina) with a raster-order address counter that wraps per frame.
- Flags frame completion so the TFT read side (port B) knows when valid image data is present.

Parameters:
- H_PIXELS, 240, pixels per line.
- V_PIXELS, 136, lines per frame. H_PIXELS*V_PIXELS must be <= 65536; default frame size is 32640.
- TIMEOUT_CYC, 50000, maximum number of Clk cycles allowed between the high byte and low byte of one pixel before the half-pixel is discarded. Default is 1 ms at 50 MHz.

Ports:
- Clk  input  1  system clock; also clocks RAM port A.
- Reset_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte; valid when rx_done=1.
- rx_done  input  1  single-cycle strobe from the UART byte receiver.
- clr  input  1  synchronous restart: address goes to 0, pixel phase goes to HI, frame_ready is cleared.
- ram_ena  output  1  RAM port A enable.
- ram_wea  output  1  RAM port A write enable.
- ram_addra  output  16  RAM port A address.
- ram_dina  output  16  RAM port A write data (RGB565).
- frame_done  output  1  one-cycle pulse coincident with the write of the last pixel of a frame.
- frame_ready  output  1  level; set once at least one full frame has been written.
- timeout_err  output  1  one-cycle pulse when a half-pixel is dropped on timeout.

Behaviour:
- Reset values (Reset_n=0, asynchronous): every output is 0, the FSM is in S_HI, the address counter is 0, the timeout counter is 0, and the high-byte register is 0.
- Byte order: the first byte of a pair is pixel[15:8], the second is pixel[7:0].
- FSM states: S_HI (waiting for high byte), S_LO (waiting for low byte), S_WR (write strobe).
  - S_HI, rx_done=1: latch rx_data into hi_byte, clear the timeout counter, go to S_LO.
  - S_LO, rx_done=1: register {hi_byte, rx_data} into ram_dina, go to S_WR.
  - S_LO, no rx_done: increment the timeout counter. When it reaches TIMEOUT_CYC-1, pulse timeout_err for one cycle, return to S_HI, and discard hi_byte. The address is unchanged.
  - S_WR: ram_ena=ram_wea=1 for exactly this one cycle, with ram_addra holding the current pixel address.
    - Next cycle: if the address equals H_PIXELS*V_PIXELS-1, it becomes 0; otherwise it increments by 1.
    - Go to S_HI. If rx_done=1 during S_WR, that byte is accepted as the next high byte and the FSM goes directly to S_LO.
- Latency: a low-byte rx_done in cycle N produces the write strobe in cycle N+1, with ram_addra and ram_dina stable in that cycle.
- Output hold: ram_ena and ram_wea are 0 in all states except S_WR. ram_addra and ram_dina hold their values between writes.
- Frame completion: frame_done=1 in the same cycle as the S_WR for address H_PIXELS*V_PIXELS-1. In the following cycle frame_ready becomes 1 and stays 1 until clr or reset.
- clr has priority over every other event:
  - Effective next cycle: FSM to S_HI, address 0, timeout counter 0, frame_ready 0.
  - Any rx_done in the same cycle is discarded.
  - An S_WR already in progress in the clr cycle still completes its write; the address is then forced to 0, not incremented.
- Reset mid-frame: all state clears immediately and any partial pixel is lost. No write is issued while Reset_n=0.
- Width rules: the address counter is 16 bits; the compare value H_PIXELS*V_PIXELS-1 is computed as a 17-bit constant and truncated to 16 bits. The timeout counter is wide enough for TIMEOUT_CYC-1 (at least 16 bits at the default).

Test Plan:
- Reset, then bytes 0xF8, 0x00 -> one cycle with ram_wea=1, ram_addra=0x0000, ram_dina=0xF800 in the cycle after the second rx_done. The address then reads 0x0001.
- Stream 2*32640 bytes with pixel value equal to its index -> exactly 32640 writes at addresses 0..32639. frame_done pulses once at address 0x7F7F, frame_ready=1 afterwards, and the next pixel is written to 0x0000.
- Send 0xAB, idle 50000 cycles, then send 0x12, 0x34 -> timeout_err pulses once and 0xAB is discarded. A single write of 0x1234 goes to the unchanged address.
- After 100 pixels (write to address 99 completed), assert clr for one cycle together with an rx_done -> that byte is ignored and frame_ready=0. The next pair is written at address 0x0000.
- rx_done asserted in the S_WR cycle (back-to-back bytes with 1-cycle spacing) -> no byte is lost and consecutive pixels go to consecutive addresses with correct data.
- Assert Reset_n=0 asynchronously while in S_LO -> all outputs go to 0 immediately without waiting for a Clk edge. After release, the next byte pair is written to address 0.

Source files
------------

// File: rtl/uart_ram_wr_ctrl.sv
// Write-side controller for the frame RAM: packs UART byte pairs into RGB565
// pixels and writes them in raster order on port A, flagging frame completion.
module uart_ram_wr_ctrl #(
   parameter int H_PIXELS    = 240,
   parameter int V_PIXELS    = 136,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   input  logic        clr,
   output logic        ram_ena,
   output logic        ram_wea,
   output logic [15:0] ram_addra,
   output logic [15:0] ram_dina,
   output logic        frame_done,
   output logic        frame_ready,
   output logic        timeout_err,
   output logic [1:0]  state_dbg
);

   localparam logic [16:0] LAST_17   = 17'(H_PIXELS * V_PIXELS - 1);
   localparam logic [15:0] LAST_ADDR = LAST_17[15:0];
   localparam int          TW        = ($clog2(TIMEOUT_CYC) > 16) ? $clog2(TIMEOUT_CYC) : 16;
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC - 1);

   // Handshake: rx_data is sampled only in a cycle where rx_done=1; there is no
   // back-pressure, every byte offered while clr=0 is consumed.
   typedef enum logic [1:0] {
      S_HI = 2'd0,
      S_LO = 2'd1,
      S_WR = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [15:0]     addr;
   logic [TW-1:0]   to_cnt;
   logic [7:0]      hi_byte;
   logic            latch_hi, load_pix, to_fire, wr_cycle;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= S_HI;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      latch_hi  = 1'b0;
      load_pix  = 1'b0;
      to_fire   = 1'b0;
      case (state)
         S_HI: if (rx_done) begin
            latch_hi  = 1'b1;
            state_nxt = S_LO;
         end
         S_LO: if (rx_done) begin
            load_pix  = 1'b1;
            state_nxt = S_WR;
         end else if (to_cnt == TO_MAX) begin
            to_fire   = 1'b1;
            state_nxt = S_HI;
         end
         S_WR: if (rx_done) begin
            latch_hi  = 1'b1;
            state_nxt = S_LO;
         end else begin
            state_nxt = S_HI;
         end
         default: state_nxt = S_HI;
      endcase
      // clr overrides everything, but an S_WR in progress still drives its write
      if (clr) begin
         state_nxt = S_HI;
         latch_hi  = 1'b0;
         load_pix  = 1'b0;
         to_fire   = 1'b0;
      end
   end

   assign wr_cycle    = (state == S_WR);
   assign ram_ena     = wr_cycle;
   assign ram_wea     = wr_cycle;
   assign ram_addra   = addr;
   assign frame_done  = wr_cycle && (addr == LAST_ADDR);
   assign timeout_err = to_fire;
   assign state_dbg   = state;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hi_byte     <= '0;
         ram_dina    <= '0;
         to_cnt      <= '0;
         addr        <= '0;
         frame_ready <= 1'b0;
      end else begin
         if (latch_hi)     hi_byte <= rx_data;
         else if (to_fire) hi_byte <= '0;

         if (load_pix) ram_dina <= {hi_byte, rx_data};

         if (clr || latch_hi || to_fire)       to_cnt <= '0;
         else if (state == S_LO && !rx_done)   to_cnt <= to_cnt + 1'b1;

         if (clr)           addr <= '0;
         else if (wr_cycle) addr <= (addr == LAST_ADDR) ? 16'd0 : addr + 16'd1;

         if (clr)             frame_ready <= 1'b0;
         else if (frame_done) frame_ready <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_ram_wr_ctrl.sv
// Bench for uart_ram_wr_ctrl on a small 16x8 frame with a short timeout;
// a byte-level model predicts every RAM write and frame/timeout event.
module tb_uart_ram_wr_ctrl;

   localparam int H     = 16;
   localparam int V     = 8;
   localparam int FRAME = H * V;
   localparam int TO    = 200;
   localparam logic [15:0] LAST = 16'(FRAME - 1);

   logic        Clk, Reset_n, rx_done, clr;
   logic [7:0]  rx_data;
   logic        ram_ena, ram_wea, frame_done, frame_ready, timeout_err;
   logic [15:0] ram_addra, ram_dina;
   logic [1:0]  state_dbg;

   uart_ram_wr_ctrl #(.H_PIXELS(H), .V_PIXELS(V), .TIMEOUT_CYC(TO)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .rx_data(rx_data), .rx_done(rx_done), .clr(clr),
      .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
      .frame_done(frame_done), .frame_ready(frame_ready), .timeout_err(timeout_err),
      .state_dbg(state_dbg)
   );

   // clock / reset
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   int n_cmp = 0, n_err = 0;
   int n_wr = 0, n_fd = 0, n_to = 0, to_exp = 0;
   logic [31:0] exp_q[$];
   logic        fr_exp = 1'b0;

   // byte-level model: pairs form pixels, addresses run modulo FRAME
   logic [15:0] addr_m = 16'd0;
   logic [7:0]  hi_m = 8'd0;
   bit          have_hi = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: one-cycle strobe, then idle cycles
   task automatic send_byte(input logic [7:0] b, input int idle);
      rx_data = b;
      rx_done = 1'b1;
      @(posedge Clk); #1;
      rx_done = 1'b0;
      if (!have_hi) begin
         hi_m    = b;
         have_hi = 1'b1;
      end else begin
         exp_q.push_back({addr_m, hi_m, b});
         addr_m  = 16'((int'(addr_m) + 1) % FRAME);
         have_hi = 1'b0;
      end
      repeat (idle) begin @(posedge Clk); #1; end
      if (have_hi && idle >= TO) begin
         have_hi = 1'b0;
         to_exp++;
      end
   endtask

   task automatic send_pix(input logic [15:0] p, input int idle);
      send_byte(p[15:8], 0);
      send_byte(p[7:0], idle);
   endtask

   task automatic do_clr(input logic with_rx, input logic [7:0] b);
      clr     = 1'b1;
      rx_done = with_rx;
      rx_data = b;
      @(posedge Clk); #1;
      clr     = 1'b0;
      rx_done = 1'b0;
      have_hi = 1'b0;
      addr_m  = 16'd0;
   endtask

   task automatic idle_cyc(input int n);
      repeat (n) begin @(posedge Clk); #1; end
   endtask

   // scoreboard / monitor
   always @(negedge Clk) begin
      logic [31:0] e;
      if (!Reset_n) fr_exp = 1'b0;
      chk("frame_ready", {31'd0, frame_ready}, {31'd0, fr_exp});
      if (ram_wea) begin
         n_wr++;
         chk("ena_in_write", {31'd0, ram_ena}, 32'd1);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none", ram_addra, ram_dina);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {16'd0, ram_addra}, {16'd0, e[31:16]});
            chk("wr_data", {16'd0, ram_dina}, {16'd0, e[15:0]});
            chk("frame_done_wr", {31'd0, frame_done}, {31'd0, (e[31:16] == LAST)});
            if (!clr && e[31:16] == LAST) fr_exp = 1'b1;
         end
      end else begin
         chk("ena_idle", {31'd0, ram_ena}, 32'd0);
         chk("frame_done_idle", {31'd0, frame_done}, 32'd0);
      end
      if (clr) fr_exp = 1'b0;
      if (frame_done) n_fd++;
      if (timeout_err) n_to++;
   end

   typedef struct {
      logic [7:0]  hi;
      logic [7:0]  lo;
      int          idle;
      logic [15:0] exp_addr;
      logic [15:0] exp_pix;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int fd0, wr0;
      vecs[0] = '{8'hF8, 8'h00, 0, 16'h0000, 16'hF800};
      vecs[1] = '{8'h07, 8'hE0, 1, 16'h0001, 16'h07E0};
      vecs[2] = '{8'h00, 8'h1F, 3, 16'h0002, 16'h001F};
      vecs[3] = '{8'hFF, 8'hFF, 0, 16'h0003, 16'hFFFF};
      vecs[4] = '{8'h12, 8'h34, 5, 16'h0004, 16'h1234};

      Reset_n = 1'b1; rx_done = 1'b0; clr = 1'b0; rx_data = 8'h00;
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_outputs", {ram_ena, ram_wea, frame_done, frame_ready, timeout_err, state_dbg}, 32'd0);
      chk("rst_addr_data", {ram_addra, ram_dina}, 32'd0);
      idle_cyc(3);
      Reset_n = 1'b1;
      idle_cyc(2);

      // table-driven pairs
      foreach (vecs[i]) begin
         send_byte(vecs[i].hi, vecs[i].idle);
         send_byte(vecs[i].lo, 0);
         @(negedge Clk);
         chk("tbl_wea", {31'd0, ram_wea}, 32'd1);
         chk("tbl_addr", {16'd0, ram_addra}, {16'd0, vecs[i].exp_addr});
         chk("tbl_data", {16'd0, ram_dina}, {16'd0, vecs[i].exp_pix});
         @(posedge Clk); #1;
         chk("tbl_addr_next", {16'd0, ram_addra}, {16'd0, vecs[i].exp_addr + 16'd1});
         chk("tbl_wea_off", {31'd0, ram_wea}, 32'd0);
      end

      // timeout boundary: TO-1 idle cycles keep the half pixel, TO drop it
      send_byte(8'h56, TO - 1);
      send_byte(8'h78, 2);
      chk("no_timeout", n_to, 0);
      send_byte(8'hAB, TO);
      chk("timeout_once", n_to, 1);
      send_pix(16'h1234, 2);

      // back-to-back bytes, strobe landing in the write cycle
      for (int i = 0; i < 24; i++) send_byte(8'($urandom_range(0, 255)), 0);
      idle_cyc(3);

      // full frame from address 0
      do_clr(1'b0, 8'h00);
      fd0 = n_fd;
      wr0 = n_wr;
      for (int i = 0; i < FRAME; i++) send_pix(16'(i), 0);
      idle_cyc(2);
      chk("frame_done_count", n_fd - fd0, 1);
      chk("frame_writes", n_wr - wr0, FRAME);
      chk("frame_ready_set", {31'd0, frame_ready}, 32'd1);
      send_pix(16'hBEEF, 2);
      chk("wrap_addr_next", {16'd0, ram_addra}, 32'd1);

      // clr with a simultaneous byte after writing address 99
      for (int i = 1; i < 100; i++) send_pix(16'(i * 3), 0);
      idle_cyc(1);
      chk("pre_clr_addr", {16'd0, ram_addra}, 32'd100);
      do_clr(1'b1, 8'hEE);
      chk("clr_frame_ready", {31'd0, frame_ready}, 32'd0);
      chk("clr_addr", {16'd0, ram_addra}, 32'd0);
      send_pix(16'hC33C, 2);

      // clr during the write cycle: write completes, address forced to 0
      send_pix(16'h1122, 0);
      do_clr(1'b0, 8'h00);
      chk("clr_wr_addr", {16'd0, ram_addra}, 32'd0);
      send_pix(16'h3344, 2);

      // randomized traffic with occasional clr and near-timeout gaps
      for (int i = 0; i < 400; i++) begin
         int idle;
         if ($urandom_range(0, 39) == 0) begin
            do_clr(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         end
         idle = ($urandom_range(0, 29) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                             : int'($urandom_range(0, 6));
         send_byte(8'($urandom_range(0, 255)), idle);
      end
      idle_cyc(3);
      chk("timeout_total", n_to, to_exp);

      // asynchronous reset while waiting for a low byte
      if (have_hi) send_byte(8'h00, 1);
      send_pix(16'h5A5A, 2);
      send_byte(8'h9A, 0);
      #2 Reset_n = 1'b0;
      #1;
      chk("arst_outputs", {ram_ena, ram_wea, frame_done, frame_ready, timeout_err, state_dbg}, 32'd0);
      chk("arst_addr_data", {ram_addra, ram_dina}, 32'd0);
      have_hi = 1'b0;
      addr_m  = 16'd0;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      idle_cyc(1);
      send_pix(16'hA55A, 2);
      chk("post_rst_addr", {16'd0, ram_addra}, 32'd1);

      idle_cyc(3);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("timeout_final", n_to, to_exp);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
